// File: rtl/riscv_pkg.sv
// Shared encodings and default widths for the data-memory arbiter slice.
package riscv_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;
  localparam int unsigned STAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating grant and CPU-stall counters for dmem_arbiter (built only with DMEM_ARB_STATS_EN).
module dmem_arb_stats
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_grant,
  input  logic              dma_grant,
  input  logic              cpu_stall,
  output logic [STAT_W-1:0] stat_cpu_grants,
  output logic [STAT_W-1:0] stat_dma_grants,
  output logic [STAT_W-1:0] stat_cpu_stall_cycles
);

  // Each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cpu_grants       <= '0;
      stat_dma_grants       <= '0;
      stat_cpu_stall_cycles <= '0;
    end else begin
      if (cpu_grant && (stat_cpu_grants != '1)) begin
        stat_cpu_grants <= stat_cpu_grants + STAT_W'(1);
      end
      if (dma_grant && (stat_dma_grants != '1)) begin
        stat_dma_grants <= stat_dma_grants + STAT_W'(1);
      end
      if (cpu_stall && (stat_cpu_stall_cycles != '1)) begin
        stat_cpu_stall_cycles <= stat_cpu_stall_cycles + STAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of the single-port Data_Memory, CPU-priority with DMA anti-starvation.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned AW             = DEF_AW,
  parameter int unsigned DW             = DEF_DW,
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned MAX_CPU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [AW-1:0]     dma_addr,
  input  logic [DW-1:0]     dma_wdata,
  output logic [DW-1:0]     dma_rdata,
  output logic              dma_ack,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wd,
`ifdef DMEM_ARB_STATS_EN
  output logic [STAT_W-1:0] stat_cpu_grants,
  output logic [STAT_W-1:0] stat_dma_grants,
  output logic [STAT_W-1:0] stat_cpu_stall_cycles,
`endif
  input  logic [DW-1:0]     mem_rd
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned SW = $clog2(MAX_CPU_STREAK + 1);

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          cpu_ack_d, dma_ack_d, mem_we_d;
  logic [DW-1:0] cpu_rdata_d, dma_rdata_d, mem_wd_d;
  logic [AW-1:0] mem_addr_d;

  assign cpu_stall = cpu_req & ~cpu_ack;

  // Next-state, arbitration and registered memory/response values.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata;
    dma_rdata_d = dma_rdata;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wd_d    = mem_wd;

    case (state_q)
      ST_IDLE: begin
        mem_addr_d = '0;
        mem_wd_d   = '0;
        if (cpu_req || dma_req) begin
          if (dma_req && (!cpu_req || (streak_q == SW'(MAX_CPU_STREAK)))) begin
            owner_d    = OWN_DMA;
            streak_d   = '0;
            mem_we_d   = dma_we;
            mem_addr_d = dma_addr;
            mem_wd_d   = dma_wdata;
          end else begin
            owner_d    = OWN_CPU;
            streak_d   = dma_req ? (streak_q + SW'(1)) : '0;
            mem_we_d   = cpu_we;
            mem_addr_d = cpu_addr;
            mem_wd_d   = cpu_wdata;
          end
          cnt_d   = CW'(LATENCY - 1);
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        mem_addr_d = (owner_q == OWN_DMA) ? dma_addr  : cpu_addr;
        mem_wd_d   = (owner_q == OWN_DMA) ? dma_wdata : cpu_wdata;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          // Last window cycle: capture read data with the ack for the owner.
          cnt_d      = '0;
          mem_addr_d = '0;
          mem_wd_d   = '0;
          state_d    = ST_RESP;
          if (owner_q == OWN_DMA) begin
            dma_ack_d = 1'b1;
            if (!dma_we) dma_rdata_d = mem_rd;
          end else begin
            cpu_ack_d = 1'b1;
            if (!cpu_we) cpu_rdata_d = mem_rd;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        mem_addr_d = '0;
        mem_wd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_CPU;
      cnt_q     <= '0;
      streak_q  <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      streak_q  <= streak_d;
      cpu_ack   <= cpu_ack_d;
      dma_ack   <= dma_ack_d;
      cpu_rdata <= cpu_rdata_d;
      dma_rdata <= dma_rdata_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wd    <= mem_wd_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic cpu_grant_c, dma_grant_c;

  assign cpu_grant_c = (state_q == ST_IDLE) && (state_d == ST_ACCESS) && (owner_d == OWN_CPU);
  assign dma_grant_c = (state_q == ST_IDLE) && (state_d == ST_ACCESS) && (owner_d == OWN_DMA);

  dmem_arb_stats u_stats (
    .clk                   (clk),
    .rst                   (rst),
    .cpu_grant             (cpu_grant_c),
    .dma_grant             (dma_grant_c),
    .cpu_stall             (cpu_stall),
    .stat_cpu_grants       (stat_cpu_grants),
    .stat_dma_grants       (stat_dma_grants),
    .stat_cpu_stall_cycles (stat_cpu_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Two instances: LATENCY=1 (main) and LATENCY=3 (write-window scenario).
module tb_dmem_arbiter;

  localparam int unsigned LAT1 = 1;
  localparam int unsigned LAT3 = 3;
  localparam int unsigned MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, cpu_ack, cpu_stall, dma_req, dma_we, dma_ack, mem_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dma_addr, dma_wdata, dma_rdata;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic        cpu_req3, cpu_we3, cpu_ack3, cpu_stall3, dma_req3, dma_we3, dma_ack3, mem_we3;
  logic [31:0] cpu_addr3, cpu_wdata3, cpu_rdata3, dma_addr3, dma_wdata3, dma_rdata3;
  logic [31:0] mem_addr3, mem_wd3, mem_rd3;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] st_cg, st_dg, st_cs, st_cg3, st_dg3, st_cs3;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  dmem_arbiter #(.AW(32), .DW(32), .LATENCY(LAT1), .MAX_CPU_STREAK(MAXS)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
`ifdef DMEM_ARB_STATS_EN
    .stat_cpu_grants(st_cg), .stat_dma_grants(st_dg), .stat_cpu_stall_cycles(st_cs),
`endif
    .mem_rd(mem_rd)
  );

  dmem_arbiter #(.AW(32), .DW(32), .LATENCY(LAT3), .MAX_CPU_STREAK(MAXS)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
    .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3), .cpu_stall(cpu_stall3),
    .dma_req(dma_req3), .dma_we(dma_we3), .dma_addr(dma_addr3), .dma_wdata(dma_wdata3),
    .dma_rdata(dma_rdata3), .dma_ack(dma_ack3),
    .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wd(mem_wd3),
`ifdef DMEM_ARB_STATS_EN
    .stat_cpu_grants(st_cg3), .stat_dma_grants(st_dg3), .stat_cpu_stall_cycles(st_cs3),
`endif
    .mem_rd(mem_rd3)
  );

  // 16-word memory behind the main instance; gold is the bench's own expectation of its contents.
  logic [31:0] mem_arr [16];
  logic [31:0] gold    [16];
  logic        mem_init;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'h0101_0101 * 32'(i)) ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= init_word(i);
    end else if (mem_we) begin
      mem_arr[mem_addr[5:2]] <= mem_wd;
    end
  end

  assign mem_rd  = mem_arr[mem_addr[5:2]];
  assign mem_rd3 = 32'h1234_5678;

  task automatic do_reset();
    cpu_req = 0; dma_req = 0; cpu_req3 = 0; dma_req3 = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    {cpu_req, cpu_we, dma_req, dma_we, cpu_req3, cpu_we3, dma_req3, dma_we3} = '0;
    {cpu_addr, cpu_wdata, dma_addr, dma_wdata} = '0;
    {cpu_addr3, cpu_wdata3, dma_addr3, dma_wdata3} = '0;
    for (int i = 0; i < 16; i++) gold[i] = init_word(i);
    rst = 1'b0;
    mem_init = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({cpu_ack, dma_ack, mem_we, cpu_ack3, mem_we3} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_ctrl got %b required 00000", {cpu_ack, dma_ack, mem_we, cpu_ack3, mem_we3});
    end
    tests_run++;
    if ({cpu_rdata, dma_rdata, mem_addr} !== 96'h0) begin
      tests_failed++; $display("FAIL reset_data got %h %h %h required 0", cpu_rdata, dma_rdata, mem_addr);
    end
    mem_init = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    cpu_we = 0; cpu_addr = 32'h10; cpu_req = 1; #1;
    tests_run++;
    if (cpu_stall !== 1'b1) begin tests_failed++; $display("FAIL rd_stall_c0 got %b required 1", cpu_stall); end
    @(negedge clk);
    tests_run++;
    if ({mem_addr, mem_we, cpu_stall, cpu_ack} !== {32'h10, 3'b010}) begin
      tests_failed++; $display("FAIL rd_c1 addr/we/stall/ack got %h %b%b%b required 10 010", mem_addr, mem_we, cpu_stall, cpu_ack);
    end
    @(negedge clk);
    tests_run++;
    if ({cpu_ack, cpu_stall, dma_ack, cpu_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
      tests_failed++; $display("FAIL rd_c2 ack/stall/dack/rdata got %b%b%b %h required 100 deadbeef", cpu_ack, cpu_stall, dma_ack, cpu_rdata);
    end
    cpu_req = 0;
    @(negedge clk);
    tests_run++;
    if ({cpu_ack, cpu_rdata, mem_addr} !== {1'b0, 32'hDEAD_BEEF, 32'h0}) begin
      tests_failed++; $display("FAIL rd_c3 ack/rdata/addr got %b %h %h required 0 deadbeef 0", cpu_ack, cpu_rdata, mem_addr);
    end
  endtask

  task automatic test_cpu_write_lat3();
    cpu_we3 = 1; cpu_addr3 = 32'h20; cpu_wdata3 = 32'hA5A5_A5A5; cpu_req3 = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (c < 4) begin
        if ({mem_we3, mem_addr3, mem_wd3, cpu_ack3} !== {(c == 1), 32'h20, 32'hA5A5_A5A5, 1'b0}) begin
          tests_failed++; $display("FAIL wr3_c%0d we/addr/wd/ack got %b %h %h %b", c, mem_we3, mem_addr3, mem_wd3, cpu_ack3);
        end
      end else if ({cpu_ack3, mem_we3, cpu_rdata3} !== {2'b10, 32'h0}) begin
        tests_failed++; $display("FAIL wr3_c4 ack/we/rdata got %b%b %h required 10 0", cpu_ack3, mem_we3, cpu_rdata3);
      end
    end
    cpu_req3 = 0;
    @(negedge clk);
    tests_run++;
    if (cpu_ack3 !== 1'b0) begin tests_failed++; $display("FAIL wr3_c5 ack got %b required 0", cpu_ack3); end
  endtask

  task automatic test_simultaneous();
    cpu_we = 0; cpu_addr = 32'h10; dma_we = 0; dma_addr = 32'h08;
    cpu_req = 1; dma_req = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      tests_run++;
      if ({cpu_ack, dma_ack} !== {(c == 2), (c == 5)}) begin
        tests_failed++; $display("FAIL sim_c%0d cpu_ack/dma_ack got %b%b required %b%b", c, cpu_ack, dma_ack, (c == 2), (c == 5));
      end
      if (c == 2) cpu_req = 0;
      if (c == 4) begin
        tests_run++;
        if (mem_addr !== 32'h08) begin tests_failed++; $display("FAIL sim_dma_addr got %h required 08", mem_addr); end
      end
      if (c == 5) begin
        tests_run++;
        if (dma_rdata !== gold[2]) begin tests_failed++; $display("FAIL sim_dma_rdata got %h required %h", dma_rdata, gold[2]); end
        dma_req = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [9:0] exp_dma;
    int n, cycles;
    exp_dma = 10'b10000_10000;
    n = 0; cycles = 0;
    cpu_we = 0; cpu_addr = 32'h14; dma_we = 0; dma_addr = 32'h18;
    cpu_req = 1; dma_req = 1;
    while (n < 10 && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (cpu_ack || dma_ack) begin
        tests_run++;
        if (dma_ack !== exp_dma[n] || cpu_ack === dma_ack) begin
          tests_failed++; $display("FAIL starve_grant%0d cpu/dma ack got %b%b required dma=%b", n, cpu_ack, dma_ack, exp_dma[n]);
        end
        n++;
      end
    end
    tests_run++;
    if (n != 10) begin tests_failed++; $display("FAIL starve_timeout got %0d grants required 10", n); end
    cpu_req = 0; dma_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'h1111_2222; cpu_req = 1;
    @(negedge clk);
    tests_run++;
    if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL rmw_pre_we got %b required 1", mem_we); end
    rst = 1'b0; #1;
    tests_run++;
    if ({mem_we, cpu_ack, dma_ack, mem_addr} !== 35'h0) begin
      tests_failed++; $display("FAIL rmw_in_reset we/acks/addr got %b%b%b %h required 000 0", mem_we, cpu_ack, dma_ack, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({mem_we, mem_addr, mem_wd, cpu_ack} !== {1'b1, 32'h30, 32'h1111_2222, 1'b0}) begin
      tests_failed++; $display("FAIL rmw_restart_c1 we/addr/wd/ack got %b %h %h %b", mem_we, mem_addr, mem_wd, cpu_ack);
    end
    gold[12] = 32'h1111_2222;
    @(negedge clk);
    tests_run++;
    if ({cpu_ack, mem_we} !== 2'b10) begin tests_failed++; $display("FAIL rmw_restart_ack ack/we got %b%b required 10", cpu_ack, mem_we); end
    cpu_req = 0;
    @(negedge clk);
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    int acks, cycles;
    do_reset();
    cpu_we = 0; cpu_addr = 32'h04; cpu_req = 1;
    acks = 0; cycles = 0;
    while (acks < 3 && cycles < 50) begin
      @(negedge clk);
      cycles++;
      if (cpu_ack) acks++;
    end
    cpu_req = 0;
    @(negedge clk);
    tests_run++;
    if ({st_cg, st_dg, st_cs} !== {32'd3, 32'd0, 32'd6}) begin
      tests_failed++; $display("FAIL stats cg/dg/cs got %0d %0d %0d required 3 0 6", st_cg, st_dg, st_cs);
    end
  endtask
`endif

  // Transaction-level model: requests are serialised, each taking LAT1+2 cycles from grant.
  task automatic test_random();
    int cyc, free_at, ack_cyc, acc_start, streak, k;
    bit busy, own_dma, t_we, e_cack, e_dack, gen, done;
    logic [31:0] t_addr, t_wdata, t_rdata, exp_crd, exp_drd;
    do_reset();
    cyc = 0; free_at = 0; ack_cyc = 0; acc_start = 0; streak = 0; k = 0;
    busy = 0; own_dma = 0; t_we = 0; done = 0;
    t_addr = 0; t_wdata = 0; t_rdata = 0; exp_crd = 0; exp_drd = 0;
    while (!done) begin
      gen    = (k < 400);
      e_cack = busy && (cyc == ack_cyc) && !own_dma;
      e_dack = busy && (cyc == ack_cyc) && own_dma;
      if (e_cack && !t_we) exp_crd = t_rdata;
      if (e_dack && !t_we) exp_drd = t_rdata;
      tests_run++;
      if ({cpu_ack, dma_ack} !== {e_cack, e_dack}) begin
        tests_failed++; $display("FAIL rand_ack cyc=%0d got %b%b required %b%b", cyc, cpu_ack, dma_ack, e_cack, e_dack);
      end
      tests_run++;
      if ({cpu_rdata, dma_rdata} !== {exp_crd, exp_drd}) begin
        tests_failed++; $display("FAIL rand_rdata cyc=%0d got %h %h required %h %h", cyc, cpu_rdata, dma_rdata, exp_crd, exp_drd);
      end
      tests_run++;
      if (cpu_stall !== (cpu_req && !e_cack)) begin
        tests_failed++; $display("FAIL rand_stall cyc=%0d got %b required %b", cyc, cpu_stall, cpu_req && !e_cack);
      end
      tests_run++;
      if (mem_we !== (busy && (cyc == acc_start) && t_we)) begin
        tests_failed++; $display("FAIL rand_we cyc=%0d got %b required %b", cyc, mem_we, busy && (cyc == acc_start) && t_we);
      end
      if (busy && cyc >= acc_start && cyc < ack_cyc) begin
        tests_run++;
        if (mem_addr !== t_addr) begin tests_failed++; $display("FAIL rand_addr cyc=%0d got %h required %h", cyc, mem_addr, t_addr); end
      end else if (!busy) begin
        tests_run++;
        if (mem_addr !== 32'h0) begin tests_failed++; $display("FAIL rand_idle_addr cyc=%0d got %h required 0", cyc, mem_addr); end
      end
      if (busy && cyc == ack_cyc) begin
        busy = 0;
        if (own_dma) dma_req = 0; else cpu_req = 0;
      end
      if (gen && !cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 32'($urandom_range(0, 15)) << 2; cpu_wdata = $urandom;
      end
      if (gen && !dma_req && $urandom_range(0, 2) == 0) begin
        dma_req = 1; dma_we = 1'($urandom_range(0, 1));
        dma_addr = 32'($urandom_range(0, 15)) << 2; dma_wdata = $urandom;
      end
      if (!busy && cyc >= free_at && (cpu_req || dma_req)) begin
        own_dma = dma_req && (!cpu_req || streak == int'(MAXS));
        if (own_dma || !dma_req) streak = 0; else streak++;
        t_we    = own_dma ? dma_we : cpu_we;
        t_addr  = own_dma ? dma_addr : cpu_addr;
        t_wdata = own_dma ? dma_wdata : cpu_wdata;
        if (t_we) gold[t_addr[5:2]] = t_wdata; else t_rdata = gold[t_addr[5:2]];
        busy = 1; acc_start = cyc + 1; ack_cyc = cyc + int'(LAT1) + 1; free_at = cyc + int'(LAT1) + 2;
      end
      cyc++; k++;
      if (!gen && !busy && !cpu_req && !dma_req) done = 1;
      if (k > 600) begin
        tests_run++; tests_failed++; $display("FAIL rand_drain_timeout busy=%b", busy);
        done = 1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write_lat3();
    test_simultaneous();
    test_starvation();
    test_reset_mid_write();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port Data_Memory between two requesters: the pipeline memory stage (CPU port) and a DMA/debug loader port (DMA port).
- Sequences each access with a fixed LATENCY-cycle memory window, a registered read-data return and a one-cycle ack.
- Generates the pipeline stall while the CPU access is pending.
- CPU has priority; a streak counter guarantees the DMA port forward progress.

Parameters:
- AW, 32, address width
- DW, 32, data width
- LATENCY, 1, memory access cycles per transaction (≥1)
- MAX_CPU_STREAK, 4, consecutive CPU grants allowed while DMA waits (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request; held with fields stable until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  combinational: cpu_req & ~cpu_ack
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same directions/widths/meaning as the CPU port
- mem_we  out  1  to Data_Memory WE
- mem_addr  out  AW  to Data_Memory A
- mem_wd  out  DW  to Data_Memory WD
- mem_rd  in  DW  from Data_Memory RD

Behaviour:
- Reset (rst=0, any time, including mid-access):
  - state=IDLE, owner=CPU, counters=0.
  - cpu_ack=dma_ack=0, cpu_rdata=dma_rdata=0, mem_we=0.
  - No write issued after reset asserts.
- FSM IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - mem_addr=0, mem_wd=0, mem_we=0.
  - If any req is high: latch owner per arbitration, load cnt=LATENCY-1, go to ACCESS.
- Arbitration:
  - Only one request high: grant it.
  - Both high: grant DMA if streak==MAX_CPU_STREAK, else CPU.
- streak (sized for MAX_CPU_STREAK):
  - Incremented on a CPU grant while dma_req=1.
  - Cleared on a DMA grant, or on a CPU grant while dma_req=0.
- ACCESS:
  - mem_addr and mem_wd are muxed from the owner's inputs.
  - mem_we = owner_we, only in the first ACCESS cycle; exactly one write strobe per write.
  - cnt decrements each cycle.
  - At cnt==0: register mem_rd into the owner's rdata (reads only; writes leave rdata unchanged), go to RESP.
- RESP:
  - Owner's ack=1 for exactly one cycle; the non-owner ack stays 0.
  - Go to IDLE.
- Latency: req sampled in IDLE at cycle 0 -> ACCESS cycles 1..LATENCY -> ack at cycle LATENCY+1.
  - Minimum turnaround is LATENCY+2 cycles per transaction.
- Requester protocol:
  - Drops req, or presents a new request, after the ack edge.
  - A req still high in IDLE is treated as a new transaction.
- A req asserted during ACCESS/RESP waits; no preemption of an in-flight access.
- rdata holds its last value until the next read completion for that port.
- mem_we is never high outside ACCESS.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_cpu_grants, stat_dma_grants and stat_cpu_stall_cycles (32 bits each).
  - Grant counters increment per grant; the stall counter increments every cycle cpu_stall=1.
  - All three saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (riscv_pkg):
  - FSM state encoding constants ST_IDLE/ST_ACCESS/ST_RESP.
  - Owner encoding OWN_CPU=0/OWN_DMA=1.
  - Default widths.
- One sub-module: dmem_arb_stats (saturating counters), instantiated only under DMEM_ARB_STATS_EN.

Test Plan:
- CPU read, LATENCY=1:
  - Stimulus: cpu_req=1, cpu_we=0, cpu_addr=0x10, mem_rd=0xDEADBEEF.
  - Response: mem_addr=0x10 in cycle 1; cpu_ack=1 and cpu_rdata=0xDEADBEEF in cycle 2; cpu_stall=1 in cycles 0-1, 0 in cycle 2.
- CPU write, LATENCY=3:
  - Stimulus: addr 0x20, wdata 0xA5A5A5A5.
  - Response: mem_we=1 only in cycle 1; mem_addr=0x20 in cycles 1-3; cpu_ack in cycle 4; cpu_rdata unchanged.
- Simultaneous cpu_req and dma_req at cycle 0:
  - Response: CPU granted first; dma_ack=0 until the DMA transaction completes; dma_ack 3 cycles after cpu_ack (LATENCY=1).
- Starvation, MAX_CPU_STREAK=4, both requests continuously high (each re-asserted after its ack):
  - Response: grant order C,C,C,C,D,C,C,C,C,D.
- Reset mid-write:
  - Stimulus: rst=0 during the first ACCESS cycle.
  - Response: mem_we drops immediately; all acks 0; state IDLE; after release, a pending cpu_req restarts from cycle 0 timing.
- DMEM_ARB_STATS_EN:
  - Stimulus: 3 CPU reads at LATENCY=1 with DMA idle.
  - Response: stat_cpu_grants=3, stat_dma_grants=0, stat_cpu_stall_cycles=6.
